// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types, frame layout and DAC register addresses for the DAC SPI engine.
package dac_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 13;
  localparam int ADDR_LSB = 8;
  localparam int DATA_W   = 8;
  localparam logic [5:0] IRSET = 6'h04;
  localparam logic [5:0] IRCML = 6'h05;
  localparam logic [5:0] QRSET = 6'h07;
  localparam logic [5:0] QRCML = 6'h08;
  function automatic logic [FRAME_W-1:0] make_frame(input logic rw,
                                                    input logic [ADDR_MSB-ADDR_LSB:0] addr,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[RW_BIT] = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_W-1:0] = data;
    return f;
  endfunction
endpackage

// File: rtl/dac_spi_if.sv
// dac_spi_if: register-access handshake between the DAC controller (master) and the SPI engine (slave).
interface dac_spi_if;
  import dac_spi_pkg::*;
  logic [ADDR_MSB-ADDR_LSB:0] spi_reg;
  logic [DATA_W-1:0]          spi_data_in;
  logic [DATA_W-1:0]          spi_data_out;
  logic                       spi_rw;
  logic                       spi_send;
  logic                       spi_done;
  modport master (output spi_reg, spi_data_in, spi_rw, spi_send, input spi_done, spi_data_out);
  modport slave  (input spi_reg, spi_data_in, spi_rw, spi_send, output spi_done, spi_data_out);
endinterface

// File: rtl/dac_spi_tick_gen.sv
// dac_spi_tick_gen: SCLK half-period counter emitting rise/fall strobes while enabled.
module dac_spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d, last;
  always_comb begin
    last  = cnt_q == LAST;
    rise  = en && last && !ph_q;
    fall  = en && last && ph_q;
    cnt_d = (!en || last) ? '0 : cnt_q + 1'b1;
    ph_d  = en && (ph_q ^ last);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
endmodule

// File: rtl/dac_spi_master.sv
// dac_spi_master: serialises single DAC register transactions onto a 4-wire mode-0 SPI port
// and returns the byte read back on read frames.
module dac_spi_master import dac_spi_pkg::*; #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  dac_spi_if.slave   bus,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_sdio,
  input  logic       dac_sdo
);
  localparam int PSH  = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
  localparam int PMAX = PSH > CS_GAP ? PSH : CS_GAP;
  localparam int PW   = PMAX > 1 ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(CS_GAP - 1);
  state_t               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]    cap_q, cap_d, dout_q, dout_d;
  logic                 done_q, done_d, cs_n_q, cs_n_d, sclk_q, sclk_d, sdio_q, sdio_d;
  logic                 rise, fall;
  dac_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk), .reset_n(reset_n), .en(state_q == SHIFT), .rise(rise), .fall(fall)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    frame_d = frame_q;
    cap_d   = cap_q;
    dout_d  = dout_q;
    done_d  = done_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    sdio_d  = sdio_q;
    unique case (state_q)
      IDLE: if (bus.spi_send) begin
        frame_d = make_frame(bus.spi_rw, bus.spi_reg, bus.spi_data_in);
        bit_d   = 4'd15;
        done_d  = 1'b0;
        cs_n_d  = 1'b0;
        sdio_d  = bus.spi_rw;
        state_d = SETUP;
      end
      SETUP: if (cnt_q == SETUP_LAST) state_d = SHIFT; else cnt_d = cnt_q + 1'b1;
      SHIFT: begin
        if (rise) begin
          sclk_d = 1'b1;
          if (frame_q[RW_BIT] && !bit_q[3]) cap_d = {cap_q[DATA_W-2:0], dac_sdo};
        end
        if (fall) begin
          sclk_d = 1'b0;
          if (bit_q == 4'd0) state_d = HOLD;
          else begin
            bit_d  = bit_q - 4'd1;
            sdio_d = frame_q[bit_q - 4'd1];
          end
        end
      end
      HOLD: if (cnt_q == HOLD_LAST) begin
        cs_n_d  = 1'b1;
        sdio_d  = 1'b0;
        state_d = GAP;
      end else cnt_d = cnt_q + 1'b1;
      GAP: if (cnt_q == GAP_LAST) begin
        done_d  = 1'b1;
        dout_d  = frame_q[RW_BIT] ? cap_q : dout_q;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      cap_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
    end
  assign dac_cs_n         = cs_n_q;
  assign dac_sclk         = sclk_q;
  assign dac_sdio         = sdio_q;
  assign bus.spi_done     = done_q;
  assign bus.spi_data_out = dout_q;
endmodule

// File: tb/tb_dac_spi_master.sv
// tb_dac_spi_master: default-timing and minimum-timing DUTs checked every cycle against a
// waveform model derived from the transaction start edge, plus directed literal checks.
module tb_dac_spi_master;
  import dac_spi_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n [2];
  logic       send [2];
  logic       rw_a [2];
  logic [5:0] reg_a [2];
  logic [7:0] din [2];
  logic [7:0] rb [2];
  logic [7:0] dout [2];
  logic       cs_n [2];
  logic       sclk [2];
  logic       sdio [2];
  logic       sdo [2];
  logic       done [2];
  int n_cmp = 0, n_bad = 0, ec = 0;
  int          t0 [2];
  bit          act [2];
  logic [15:0] mf [2];
  logic [7:0]  exp_dout [2];
  int          rc [2], nf [2], fr [2], lr [2], csf [2], drc [2];
  logic [15:0] cf [2], lf [2];
  logic        pcs [2], psc [2], pdn [2];
  localparam logic [5:0]  SEQ_R [4] = '{IRCML, QRCML, IRSET, QRSET};
  localparam logic [15:0] SEQ_F [4] = '{16'h0580, 16'h0880, 16'h04AA, 16'h079F};

  function automatic int dv(int g); return g == 0 ? 4 : 1; endfunction
  function automatic int sv(int g); return g == 0 ? 2 : 1; endfunction
  function automatic int hv(int g); return g == 0 ? 2 : 1; endfunction
  function automatic int gv(int g); return g == 0 ? 4 : 1; endfunction
  function automatic int lat(int g); return sv(g) + 32 * dv(g) + hv(g) + gv(g); endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    dac_spi_if bus ();
    assign bus.spi_reg     = reg_a[g];
    assign bus.spi_data_in = din[g];
    assign bus.spi_rw      = rw_a[g];
    assign bus.spi_send    = send[g];
    assign done[g]         = bus.spi_done;
    assign dout[g]         = bus.spi_data_out;
    assign sdo[g] = (rc[g] >= 8 && rc[g] < 16) ? rb[g][3'(15 - rc[g])] : 1'b0;
    dac_spi_master #(
      .CLK_DIV(g == 0 ? 4 : 1), .CS_SETUP(g == 0 ? 2 : 1),
      .CS_HOLD(g == 0 ? 2 : 1), .CS_GAP(g == 0 ? 4 : 1)
    ) dut (
      .clk(clk), .reset_n(rst_n[g]), .bus(bus),
      .dac_cs_n(cs_n[g]), .dac_sclk(sclk[g]), .dac_sdio(sdio[g]), .dac_sdo(sdo[g])
    );
  end

  task automatic chk(string name, int g, int actual, int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, g, $time, actual, expected);
    end
  endtask

  // Model: a transaction starts on any edge where send is seen and the previous one is over.
  always @(posedge clk) begin
    ec = ec + 1;
    for (int g = 0; g < 2; g++)
      if (!rst_n[g]) begin
        act[g] = 0;
        exp_dout[g] = 8'h00;
      end else begin
        if (act[g] && ec - t0[g] == lat(g) && mf[g][15]) exp_dout[g] = rb[g];
        if (send[g] && (!act[g] || ec - t0[g] > lat(g))) begin
          act[g] = 1;
          t0[g] = ec;
          mf[g] = {rw_a[g], 1'b0, reg_a[g], din[g]};
        end
      end
  end

  always @(negedge clk) begin
    int k, n, D, S, H, L;
    logic ecs, esc, esd, edn;
    logic [7:0] edo;
    for (int g = 0; g < 2; g++) begin
      D = dv(g); S = sv(g); H = hv(g); L = lat(g);
      k = ec - t0[g];
      ecs = 1'b1; esc = 1'b0; esd = 1'b0; edn = 1'b1;
      edo = rst_n[g] ? exp_dout[g] : 8'h00;
      if (rst_n[g] && act[g] && k < L) begin
        edn = 1'b0;
        ecs = k >= S + 32 * D + H;
        esc = (k >= S && k < S + 32 * D) ? ((k - S) % (2 * D) >= D) : 1'b0;
        n = k < S ? 0 : (k - S) / (2 * D);
        if (n > 15) n = 15;
        esd = ecs ? 1'b0 : mf[g][15 - n];
      end
      chk("cs_n", g, cs_n[g], ecs);
      chk("sclk", g, sclk[g], esc);
      chk("sdio", g, sdio[g], esd);
      chk("spi_done", g, done[g], edn);
      chk("spi_data_out", g, dout[g], edo);
      if (pcs[g] && !cs_n[g]) begin
        rc[g] = 0;
        cf[g] = '0;
        csf[g] = ec;
      end
      if (!psc[g] && sclk[g]) begin
        chk("rise_cs_low", g, cs_n[g], 0);
        if (rc[g] == 0) fr[g] = ec;
        lr[g] = ec;
        cf[g] = {cf[g][14:0], sdio[g]};
        rc[g]++;
        if (rc[g] == 16) begin
          lf[g] = cf[g];
          nf[g]++;
        end
      end
      if (!pdn[g] && done[g]) drc[g]++;
      pcs[g] = cs_n[g];
      psc[g] = sclk[g];
      pdn[g] = done[g];
    end
  end

  task automatic xfer(int g, logic rw, logic [5:0] r, logic [7:0] d, bit now, output int l);
    if (!now) begin @(negedge clk); #1; end
    rw_a[g] = rw; reg_a[g] = r; din[g] = d; send[g] = 1'b1;
    @(negedge clk); #1;
    send[g] = 1'b0;
    l = 0;
    while (!done[g] && l < 1000) begin @(negedge clk); #1; l++; end
  endtask

  initial begin
    int l, n0, d0, c0;
    logic [15:0] fsadj;
    logic [7:0] sd;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b1; send[g] = 1'b0; rw_a[g] = 1'b0; reg_a[g] = '0; din[g] = '0; rb[g] = '0;
      act[g] = 0; t0[g] = 0; mf[g] = '0; exp_dout[g] = '0;
      rc[g] = 0; nf[g] = 0; fr[g] = 0; lr[g] = 0; csf[g] = 0; drc[g] = 0; cf[g] = '0; lf[g] = '0;
      pcs[g] = 1'b1; psc[g] = 1'b0; pdn[g] = 1'b1;
    end
    #1 rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    xfer(0, 1'b0, IRCML, 8'h80, 0, l);
    chk("wr_latency", 0, l, 136);
    chk("wr_frame", 0, lf[0], 16'h0580);
    chk("wr_rises", 0, rc[0], 16);
    chk("wr_rise_span", 0, lr[0] - fr[0], 120);
    chk("wr_dout", 0, dout[0], 8'h00);
    rb[0] = 8'hA5;
    xfer(0, 1'b1, IRSET, 8'h00, 0, l);
    chk("rd_latency", 0, l, 136);
    chk("rd_frame", 0, lf[0], 16'h8400);
    chk("rd_dout", 0, dout[0], 8'hA5);
    fsadj = 16'h1F2A;
    n0 = nf[0];
    for (int i = 0; i < 4; i++) begin
      sd = i < 2 ? 8'h80 : 8'h80 | (i == 2 ? {2'b00, fsadj[5:0]} : {2'b00, fsadj[13:8]});
      xfer(0, 1'b0, SEQ_R[i], sd, 0, l);
      chk("seq_frame", 0, lf[0], SEQ_F[i]);
      chk("seq_count", 0, nf[0] - n0, i + 1);
    end
    chk("seq_dout_kept", 0, dout[0], 8'hA5);
    n0 = nf[0]; d0 = drc[0];
    @(negedge clk); #1;
    rw_a[0] = 1'b0; reg_a[0] = QRSET; din[0] = 8'h55; send[0] = 1'b1;
    @(negedge clk); #1 send[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1 rw_a[0] = 1'b1; reg_a[0] = 6'h3F; din[0] = 8'hFF; send[0] = 1'b1;
    @(negedge clk); #1 send[0] = 1'b0;
    l = 0;
    while (!done[0] && l < 1000) begin @(negedge clk); #1; l++; end
    repeat (20) @(negedge clk);
    chk("busy_frame", 0, lf[0], 16'h0755);
    chk("busy_frames", 0, nf[0] - n0, 1);
    chk("busy_done_rises", 0, drc[0] - d0, 1);
    @(negedge clk); #1;
    rw_a[0] = 1'b0; reg_a[0] = QRSET; din[0] = 8'h3C; send[0] = 1'b1;
    @(negedge clk); #1 send[0] = 1'b0;
    repeat (55) @(negedge clk);
    #1 chk("pre_rst_sclk", 0, sclk[0], 1);
    chk("pre_rst_sdio", 0, sdio[0], 1);
    rst_n[0] = 1'b0;
    #1 chk("rst_cs_n", 0, cs_n[0], 1);
    chk("rst_sclk", 0, sclk[0], 0);
    chk("rst_sdio", 0, sdio[0], 0);
    chk("rst_done", 0, done[0], 1);
    chk("rst_dout", 0, dout[0], 8'h00);
    repeat (2) @(negedge clk);
    #1 rst_n[0] = 1'b1;
    xfer(0, 1'b0, IRCML, 8'h80, 0, l);
    chk("post_rst_latency", 0, l, 136);
    chk("post_rst_frame", 0, lf[0], 16'h0580);
    xfer(1, 1'b0, IRCML, 8'h11, 0, l);
    chk("min_latency", 1, l, 35);
    chk("min_frame", 1, lf[1], 16'h0511);
    chk("min_rise_span", 1, lr[1] - fr[1], 30);
    c0 = csf[1];
    xfer(1, 1'b0, QRCML, 8'h22, 1, l);
    chk("b2b_accept_gap", 1, csf[1] - c0, 36);
    chk("b2b_latency", 1, l, 35);
    chk("b2b_frame", 1, lf[1], 16'h0822);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        if (done[g]) rb[g] = 8'($urandom);
        send[g] = $urandom_range(0, 5) == 0;
        rw_a[g] = 1'($urandom);
        reg_a[g] = 6'($urandom);
        din[g] = 8'($urandom);
      end
    end
    #1 send[0] = 1'b0; send[1] = 1'b0;
    repeat (300) @(negedge clk);
    chk("final_idle", 0, done[0], 1);
    chk("final_idle", 1, done[1], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
